// File: rtl/gpu_cmd_queue.sv
// rtl/gpu_cmd_queue.sv - FIFO-buffered draw-command issue queue feeding the rasterizer
package gpu_cmd_pkg;
  typedef logic [1:0] raster_command_t;
endpackage

module gpu_cmd_queue
  import gpu_cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst_async,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  raster_command_t          push_command,
  input  logic [7:0]               push_x0,
  input  logic [7:0]               push_y0,
  input  logic [7:0]               push_x1,
  input  logic [7:0]               push_y1,
  input  logic [2:0]               push_colour,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle,
  output raster_command_t          gpu_command,
  output logic [7:0]               gpu_x0,
  output logic [7:0]               gpu_y0,
  output logic [7:0]               gpu_x1,
  output logic [7:0]               gpu_y1,
  output logic [2:0]               gpu_colour,
  output logic                     gpu_execute_request,
  input  logic                     gpu_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    raster_command_t command;
    logic [7:0]      x0;
    logic [7:0]      y0;
    logic [7:0]      x1;
    logic [7:0]      y1;
    logic [2:0]      colour;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_DONE} state_t;

  state_t          state, state_nxt;
  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          gpu_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic            req_q;
  logic            do_push;
  logic            do_pop;

  assign wr_entry   = '{command: push_command, x0: push_x0, y0: push_y0,
                        x1: push_x1, y1: push_y1, colour: push_colour};
  assign push_ready = (count_q != CW'(DEPTH));
  // flush beats a simultaneous push; a pop from the already-loaded head still goes out
  assign do_push    = push_valid & push_ready & ~flush;
  assign do_pop     = (state == S_IDLE) && (count_q != '0) && !gpu_busy;

  assign count               = count_q;
  assign idle                = (state == S_IDLE) && (count_q == '0) && !gpu_busy;
  assign gpu_execute_request = req_q;
  assign gpu_command         = gpu_q.command;
  assign gpu_x0              = gpu_q.x0;
  assign gpu_y0              = gpu_q.y0;
  assign gpu_x1              = gpu_q.x1;
  assign gpu_y1              = gpu_q.y1;
  assign gpu_colour          = gpu_q.colour;

  // Command storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue registers: operands latched at pop, strobe high for the REQ cycle only
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      gpu_q <= '0;
      req_q <= 1'b0;
    end else begin
      req_q <= do_pop;
      if (do_pop) gpu_q <= mem[rd_ptr];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // FSM next state; busy is ignored in ACK while the rasterizer latches
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (do_pop) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_ACK;
      S_ACK:   state_nxt = S_DONE;
      S_DONE:  if (!gpu_busy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_gpu_cmd_queue.sv
// tb/tb_gpu_cmd_queue.sv - self-checking bench for gpu_cmd_queue
module tb_gpu_cmd_queue;
  import gpu_cmd_pkg::*;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            n_rst_async;
  logic            push_valid;
  logic            push_ready;
  raster_command_t push_command;
  logic [7:0]      push_x0, push_y0, push_x1, push_y1;
  logic [2:0]      push_colour;
  logic            flush;
  logic [3:0]      count;
  logic            idle;
  raster_command_t gpu_command;
  logic [7:0]      gpu_x0, gpu_y0, gpu_x1, gpu_y1;
  logic [2:0]      gpu_colour;
  logic            gpu_execute_request;
  logic            gpu_busy;

  gpu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst_async(n_rst_async),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_command(push_command), .push_x0(push_x0), .push_y0(push_y0),
    .push_x1(push_x1), .push_y1(push_y1), .push_colour(push_colour),
    .flush(flush), .count(count), .idle(idle),
    .gpu_command(gpu_command), .gpu_x0(gpu_x0), .gpu_y0(gpu_y0),
    .gpu_x1(gpu_x1), .gpu_y1(gpu_y1), .gpu_colour(gpu_colour),
    .gpu_execute_request(gpu_execute_request), .gpu_busy(gpu_busy)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
    logic [2:0] col;
  } pay_t;

  typedef struct {
    bit   pv;
    pay_t pay;
    bit   busy;
    bit   e_req;
    int   e_cnt;
    bit   e_idle;
    pay_t e_ops;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: queued payloads plus cycles elapsed since the last load
  pay_t mq[$];
  int   since;
  pay_t last_ops;
  // rasterizer model
  int   busy_rem;
  int   busy_len;
  bit   busy_rand;
  bit   force_busy;
  bit   last_req;
  int   n_issued;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pay_t dut_pay();
    return {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour};
  endfunction

  function automatic pay_t rnd_pay();
    pay_t p;
    p = {$urandom, $urandom};
    return p;
  endfunction

  task automatic set_push(input pay_t p);
    push_command = p.cmd;
    push_x0 = p.x0; push_y0 = p.y0; push_x1 = p.x1; push_y1 = p.y1;
    push_colour = p.col;
  endtask

  task automatic model_reset();
    mq.delete();
    since    = -1;
    last_ops = '0;
    busy_rem = 0;
    last_req = 1'b0;
  endtask

  task automatic do_reset();
    n_rst_async = 1'b0;
    push_valid = 1'b0; flush = 1'b0; gpu_busy = 1'b0; force_busy = 1'b0;
    set_push('0);
    model_reset();
    #25;
    @(negedge clk);
    n_rst_async = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive inputs, advance the reference at the edge, compare after it
  task automatic tick(input bit pv, input pay_t p, input bit fl);
    bit accept;
    if (last_req) busy_rem = busy_rand ? int'($urandom_range(1, 3)) : busy_len;
    gpu_busy   = force_busy || (busy_rem > 0);
    push_valid = pv;
    set_push(p);
    flush      = fl;
    @(posedge clk);
    accept = pv && (mq.size() < DEPTH) && !fl;
    if (since < 0) begin
      if (mq.size() > 0 && !gpu_busy) begin
        last_ops = mq.pop_front();
        since    = 1;
      end
    end else if (since < 3) begin
      since++;
    end else if (!gpu_busy) begin
      since = -1;
    end
    if (fl) mq.delete();
    if (accept) mq.push_back(p);
    if (busy_rem > 0) busy_rem--;
    #1;
    last_req = gpu_execute_request;
    if (gpu_execute_request) n_issued++;
    chk("req", gpu_execute_request, since == 1);
    chk("count", count, mq.size());
    chk("push_ready", push_ready, mq.size() != DEPTH);
    chk("operands", dut_pay(), last_ops);
    chk("idle", idle, (since < 0) && (mq.size() == 0) && !gpu_busy);
  endtask

  vec_t tbl[10];
  pay_t p1, p2;

  initial begin
    busy_len = 1; busy_rand = 1'b0; n_issued = 0;
    p1 = {2'd1, 8'd10, 8'd20, 8'd30, 8'd40, 3'd3};
    p2 = {2'd2, 8'd200, 8'd7, 8'd99, 8'd1, 3'd5};

    // reset values, checked while reset is still asserted
    n_rst_async = 1'b0;
    push_valid = 1'b0; flush = 1'b0; gpu_busy = 1'b0; force_busy = 1'b0;
    set_push('0);
    model_reset();
    #25;
    chk("rst_req", gpu_execute_request, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_ready", push_ready, 1'b1);
    chk("rst_ops", dut_pay(), '0);
    chk("rst_idle", idle, 1'b1);
    @(negedge clk);
    n_rst_async = 1'b1;
    @(posedge clk);
    #1;

    // single command then busy-at-start, cycle by cycle
    tbl[0] = '{1, p1, 0, 0, 1, 0, '0};
    tbl[1] = '{0, '0, 0, 1, 0, 0, p1};
    tbl[2] = '{0, '0, 0, 0, 0, 0, p1};
    tbl[3] = '{0, '0, 1, 0, 0, 0, p1};
    tbl[4] = '{0, '0, 1, 0, 0, 0, p1};
    tbl[5] = '{0, '0, 0, 0, 0, 1, p1};
    tbl[6] = '{0, '0, 1, 0, 0, 0, p1};
    tbl[7] = '{1, p2, 1, 0, 1, 0, p1};
    tbl[8] = '{0, '0, 1, 0, 1, 0, p1};
    tbl[9] = '{0, '0, 0, 1, 0, 0, p2};
    for (int i = 0; i < 10; i++) begin
      push_valid = tbl[i].pv;
      set_push(tbl[i].pay);
      gpu_busy = tbl[i].busy;
      flush = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_req", i), gpu_execute_request, tbl[i].e_req);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
      chk($sformatf("tbl%0d_ready", i), push_ready, 1'b1);
      chk($sformatf("tbl%0d_ops", i), dut_pay(), tbl[i].e_ops);
    end

    // busy hold-off: rasterizer busy 5 cycles per command
    do_reset();
    busy_len = 5; n_issued = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, rnd_pay(), 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, '0, 1'b0);
    chk("holdoff_issued", n_issued, 3);

    // full and overflow
    force_busy = 1'b1; busy_len = 1;
    for (int i = 0; i < 10; i++) tick(1'b1, rnd_pay(), 1'b0);
    chk("full_count", count, DEPTH);
    chk("full_ready", push_ready, 1'b0);
    force_busy = 1'b0; n_issued = 0;
    for (int i = 0; i < 60; i++) tick(1'b0, '0, 1'b0);
    chk("full_issued", n_issued, 8);

    // randomized traffic across pointer wrap
    busy_rand = 1'b1; n_issued = 0;
    for (int i = 0; i < 200; i++) begin
      tick(($urandom_range(0, 1) == 1), rnd_pay(), 1'b0);
      if (count > DEPTH) chk("wrap_count_bound", count, DEPTH);
    end
    for (int i = 0; i < 60; i++) tick(1'b0, '0, 1'b0);
    chk("wrap_enough", n_issued >= 20, 1'b1);
    chk("wrap_drained_idle", idle, 1'b1);
    busy_rand = 1'b0;

    // flush with an in-flight command and a simultaneous push
    busy_len = 5; n_issued = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, rnd_pay(), 1'b0);
    for (int k = 0; k < 20 && since < 3; k++) tick(1'b0, '0, 1'b0);
    chk("flush_reached_done", since >= 3, 1'b1);
    tick(1'b1, rnd_pay(), 1'b1);
    chk("flush_count", count, 0);
    for (int i = 0; i < 30; i++) tick(1'b0, '0, 1'b0);
    chk("flush_issued", n_issued, 1);

    // asynchronous reset during ACK with 4 queued
    busy_len = 2;
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, rnd_pay(), 1'b0);
    force_busy = 1'b0;
    for (int k = 0; k < 20 && since != 2; k++) tick(1'b0, '0, 1'b0);
    chk("areset_reached_ack", since, 2);
    chk("areset_queued", count, 4);
    #3;
    n_rst_async = 1'b0;
    gpu_busy = 1'b0;
    #1;
    chk("areset_req", gpu_execute_request, 1'b0);
    chk("areset_count", count, 0);
    chk("areset_ready", push_ready, 1'b1);
    chk("areset_ops", dut_pay(), '0);
    chk("areset_idle", idle, 1'b1);
    model_reset();
    @(negedge clk);
    n_rst_async = 1'b1;
    n_issued = 0;
    for (int i = 0; i < 20; i++) tick(1'b0, '0, 1'b0);
    chk("areset_no_issue", n_issued, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
